bsg_muxn_gatestack_buffered: RTL and testbench

- Per-bit N-way selector: each bit of the output word independently picks the same bit from one of els_p input words, steered by a per-bit binary select field.
- Generalises the 2-input per-bit gatestack mux in input count and width.
- Adds a valid/ready input handshake, a two-entry output buffer, and a sticky out-of-range select error flag.
- Sits between datapath stages that need per-bit steering with flow control, e.g. bypass/merge networks.

---
 rtl/bsg_muxn_gatestack_buffered.sv | 96 +++++++++
 tb/tb_bsg_muxn_gatestack_buffered.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_muxn_gatestack_buffered.sv
`default_nettype none
// ============================================================================
// Module   : bsg_muxn_gatestack_buffered
// Purpose  : Per-bit N-way selector with valid/ready intake, 2-entry output
//            FIFO and sticky out-of-range select error flag.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_muxn_gatestack_buffered #(
  parameter int width_p = 16,
  parameter int els_p   = 4,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [els_p*width_p-1:0]       data_i,
  input  logic [width_p*lg_els_lp-1:0]   sel_i,
  input  logic                           v_i,
  output logic                           ready_o,
  output logic [width_p-1:0]             data_o,
  output logic                           v_o,
  input  logic                           yumi_i,
  output logic                           err_o
);

  logic [width_p-1:0] w_result;
  logic [width_p-1:0] w_oob;

  for (genvar b = 0; b < width_p; b++) begin : g_bit
    logic [lg_els_lp-1:0] w_sel;
    logic [els_p-1:0]     w_hit;

    assign w_sel = sel_i[b*lg_els_lp +: lg_els_lp];

    for (genvar k = 0; k < els_p; k++) begin : g_el
      assign w_hit[k] = (w_sel == lg_els_lp'(k)) & data_i[k*width_p + b];
    end

    // An unmatched select yields no hit, so out-of-range bits read as 0.
    assign w_result[b] = |w_hit;

    if ((1 << lg_els_lp) == els_p) begin : g_pow2
      assign w_oob[b] = 1'b0;
    end else begin : g_npow2
      assign w_oob[b] = ({1'b0, w_sel} >= (lg_els_lp+1)'(els_p));
    end
  end

  logic [width_p-1:0] r_mem [2];
  logic               r_head;
  logic [1:0]         r_count;
  logic               r_err;
  logic               w_enq;
  logic               w_deq;
  logic               w_tail;

  // Gating with reset keeps ready low while the block is held in reset.
  assign ready_o = ~reset_i & (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_head];
  assign err_o   = r_err;

  assign w_enq  = v_i & ready_o;
  assign w_deq  = yumi_i & v_o;
  assign w_tail = r_head ^ (r_count == 2'd1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_count  <= 2'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_enq) begin
        r_mem[w_tail] <= w_result;
      end
      if (w_deq) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
      if (w_enq & (|w_oob)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_muxn_gatestack_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_muxn_gatestack_buffered
// Purpose  : Randomized scoreboard bench for the buffered per-bit N-way mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_muxn_gatestack_buffered;
  localparam int W  = 16;
  localparam int LG = 2;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [4*W-1:0]  data_i;
  logic [W*LG-1:0] sel_i;
  logic            v_i;
  logic            yumi_i;
  logic            ready0, v0, err0, ready1, v1, err1;
  logic [W-1:0]    d0, d1;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int mcnt  = 0;
  bit merr1 = 1'b0;

  always #5 clk = ~clk;

  bsg_muxn_gatestack_buffered #(.width_p(W), .els_p(4)) u0 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .sel_i(sel_i),
    .v_i(v_i), .ready_o(ready0), .data_o(d0), .v_o(v0),
    .yumi_i(yumi_i), .err_o(err0)
  );

  bsg_muxn_gatestack_buffered #(.width_p(W), .els_p(3)) u1 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i[3*W-1:0]), .sel_i(sel_i),
    .v_i(v_i), .ready_o(ready1), .data_o(d1), .v_o(v1),
    .yumi_i(yumi_i), .err_o(err1)
  );

  // Output bit b is bit b of word sel_b, or 0 when sel_b names no word.
  function automatic logic [W-1:0] ref_mux(input logic [4*W-1:0] d,
                                           input logic [W*LG-1:0] s, input int els);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W; b++) begin
      int k;
      k = int'(s[b*LG +: LG]);
      if (k < els) r[b] = d[k*W + b];
    end
    return r;
  endfunction

  function automatic bit ref_oob(input logic [W*LG-1:0] s, input int els);
    bit o;
    o = 1'b0;
    for (int b = 0; b < W; b++) begin
      if (int'(s[b*LG +: LG]) >= els) o = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Recorder: checks occupancy/err against the model, then books enqueues.
  always @(negedge clk) begin
    if (!reset_i) begin
      chk("v0", W'(v0), W'(mcnt != 0));
      chk("ready0", W'(ready0), W'(mcnt != 2));
      chk("v1", W'(v1), W'(mcnt != 0));
      chk("ready1", W'(ready1), W'(mcnt != 2));
      chk("err0", W'(err0), '0);
      chk("err1", W'(err1), W'(merr1));
      if (v_i && mcnt != 2) begin
        q0.push_back(ref_mux(data_i, sel_i, 4));
        q1.push_back(ref_mux(data_i, sel_i, 3));
        if (ref_oob(sel_i, 3)) merr1 = 1'b1;
      end
      mcnt = mcnt + int'(v_i && mcnt != 2) - int'(yumi_i && mcnt != 0);
    end
  end

  // Monitor: compares data each time the consumer takes a word.
  always @(negedge clk) begin
    if (!reset_i && yumi_i && v0) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop: got output word, want none (scoreboard empty)");
      end else begin
        chk("data0", d0, q0.pop_front());
        chk("data1", d1, q1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_word(input bit in_range);
    data_i = {$urandom, $urandom};
    sel_i  = $urandom;
    if (in_range) begin
      for (int b = 0; b < W; b++) sel_i[b*LG +: LG] = LG'($urandom_range(0, 2));
    end
  endtask

  task automatic drain();
    v_i = 1'b0;
    for (int i = 0; i < 10 && v0; i++) begin
      yumi_i = 1'b1;
      step();
    end
    yumi_i = 1'b0;
    total++;
    if (v0) begin
      bad++;
      $display("FAIL drain: got v_o=1 after 10 cycles, want 0");
    end
  endtask

  task automatic rand_phase(input int n, input bit in_range);
    for (int i = 0; i < n; i++) begin
      v_i    = ($urandom_range(0, 3) != 0);
      rand_word(in_range);
      yumi_i = v0 && ($urandom_range(0, 1) == 1);
      step();
    end
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; data_i = '0; sel_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_v", W'(v0), '0);
    chk("rst_ready", W'(ready0), '0);
    chk("rst_err", W'(err1), '0);
    chk("rst_data", d0, '0);
    reset_i = 1'b0;
    step();

    // Streaming: eight words with the consumer always taking.
    for (int i = 0; i < 8; i++) begin
      v_i = 1'b1;
      rand_word(1'b1);
      yumi_i = v0;
      step();
    end
    drain();

    // Backpressure: third word waits until one dequeue frees a slot.
    v_i = 1'b1; rand_word(1'b1); step();
    rand_word(1'b1); step();
    rand_word(1'b1);
    repeat (3) step();
    yumi_i = 1'b1; step();
    yumi_i = 1'b0; step();
    drain();

    // Simultaneous enqueue/dequeue at a single resident word.
    v_i = 1'b1; rand_word(1'b1); step();
    rand_word(1'b1); yumi_i = 1'b1; step();
    v_i = 1'b0; yumi_i = 1'b0; step();
    drain();

    rand_phase(200, 1'b1);

    // Directed steering: fields cycle 0,1,2,3 from bit 0.
    data_i = {16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000};
    sel_i  = {4{8'hE4}};
    v_i = 1'b1; step();
    v_i = 1'b0;
    @(negedge clk);
    chk("steer0", d0, 16'h2222);
    chk("steer1", d1, 16'h2222);
    step();
    drain();

    // Bit 5 selects word 3, which does not exist in the 3-input instance.
    data_i = {4{16'hFFFF}};
    sel_i  = '0;
    sel_i[5*LG +: LG] = 2'd3;
    v_i = 1'b1; step();
    v_i = 1'b0;
    @(negedge clk);
    chk("oob1", d1, 16'hFFDF);
    chk("oob0", d0, 16'hFFFF);
    chk("oob_err", W'(err1), 16'h0001);
    step();
    drain();

    rand_phase(300, 1'b0);

    // Fill to two entries, then reset mid-operation.
    v_i = 1'b1;
    repeat (3) begin rand_word(1'b0); step(); end
    v_i = 1'b0;
    reset_i = 1'b1;
    #1;
    q0.delete(); q1.delete(); mcnt = 0; merr1 = 1'b0;
    chk("mid_v", W'(v0), '0);
    chk("mid_err", W'(err1), '0);
    chk("mid_data0", d0, '0);
    chk("mid_data1", d1, '0);
    step();
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_ready", W'(ready0), 16'h0001);
    step();

    rand_phase(100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
